// File: rtl/lstm_gate_scheduler_pkg.sv
// Shared definitions for the LSTM gate scheduler.
//   log2         - ceiling log2, used to size counters
//   bitwidth/lw  - fixed-point word width and packed result-vector width
//   state_t      - scheduler FSM encoding
//   GATE_*       - gate index constants
//   next_gate    - lowest enabled gate at or above a start index
package lstm_gate_scheduler_pkg;

    function automatic int log2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int lw(input int nrow, input int qn, input int qm);
        return bitwidth(qn, qm) * nrow;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EMIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_C = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    // Returned by next_gate when no enabled gate remains.
    localparam logic [2:0] NO_GATE = 3'd4;

    // Scanning downward leaves the lowest qualifying gate as the result.
    function automatic logic [2:0] next_gate(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = NO_GATE;
        for (int g = 3; g >= 0; g--) begin
            if (3'(g) >= from && mask[g]) r = 3'(g);
        end
        return r;
    endfunction

endpackage

// File: rtl/lstm_gate_scheduler_watchdog.sv
// sched_watchdog: counts enabled cycles and flags expiry on the cycle in
// which the TIMEOUT-th enabled cycle elapses.
//   clk, reset - clock, synchronous active-high reset
//   clear      - zero the count
//   en         - count this cycle
//   expired    - TIMEOUT enabled cycles have elapsed (including this one)
module sched_watchdog
    import lstm_gate_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = log2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (en)        count <= count + CW'(1);
    end

    assign expired = en && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/lstm_gate_scheduler.sv
// lstm_gate_scheduler: runs one shared mat-vec engine over the enabled LSTM
// gates, W.x then U.h per gate, and hands each result downstream.
//   clk, reset            - clock, synchronous active-high reset
//   start, gate_en        - begin a sequence over the enabled gates
//   busy, done, err       - status; done pulses once per sequence
//   eng_rst, eng_done,
//   eng_result            - engine control / completion / output vector
//   sel_gate, sel_op      - weight/operand select for the current job
//   res_valid, res_ready,
//   res_data, res_gate,
//   res_op                - captured result with valid/ready handshake
module lstm_gate_scheduler
    import lstm_gate_scheduler_pkg::*;
#(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int DSP48_PER_ROW = 2,
    parameter int TIMEOUT       = 2 * NCOL * DSP48_PER_ROW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [3:0]                  gate_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        eng_rst,
    input  logic                        eng_done,
    input  logic [lw(NROW,QN,QM)-1:0]   eng_result,
    output logic [1:0]                  sel_gate,
    output logic                        sel_op,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [lw(NROW,QN,QM)-1:0]   res_data,
    output logic [1:0]                  res_gate,
    output logic                        res_op
);
    state_t     state, state_n;
    logic [3:0] mask;
    logic       zero_done, zero_done_n;
    logic [2:0] nxt;
    logic       last_job;
    logic       expired;

    sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != S_RUN),
        .en      (state == S_RUN),
        .expired (expired)
    );

    // Gate following the current one; the job is last once op 1 is done
    // and no higher gate is enabled.
    assign nxt      = next_gate(mask, 3'({1'b0, sel_gate}) + 3'd1);
    assign last_job = sel_op && (nxt == NO_GATE);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        zero_done_n = 1'b0;
        unique case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    if (gate_en == 4'd0) begin
                        state_n     = S_IDLE;
                        zero_done_n = 1'b1;
                    end else begin
                        state_n = S_RUN;
                    end
                end
            end
            // Completion wins over a coincident watchdog expiry.
            S_RUN: begin
                if (eng_done)     state_n = S_EMIT;
                else if (expired) state_n = S_ERR;
            end
            S_EMIT: begin
                if (res_ready) state_n = last_job ? S_IDLE : S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= '0;
            zero_done <= 1'b0;
            sel_gate  <= '0;
            sel_op    <= 1'b0;
            res_data  <= '0;
            res_gate  <= '0;
            res_op    <= 1'b0;
        end else begin
            zero_done <= zero_done_n;
            unique case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        mask     <= gate_en;
                        sel_gate <= 2'(next_gate(gate_en, 3'd0));
                        sel_op   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (eng_done) begin
                        res_data <= eng_result;
                        res_gate <= sel_gate;
                        res_op   <= sel_op;
                    end
                end
                S_EMIT: begin
                    if (res_ready && !last_job) begin
                        if (!sel_op) begin
                            sel_op <= 1'b1;
                        end else begin
                            sel_op   <= 1'b0;
                            sel_gate <= 2'(nxt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == S_RUN) || (state == S_EMIT);
    assign err       = (state == S_ERR);
    assign eng_rst   = (state != S_RUN);
    assign res_valid = (state == S_EMIT);
    // Sequence completion lands in the final handshake cycle; an empty mask
    // reports one cycle after start.
    assign done      = zero_done || (res_valid && res_ready && last_job);
endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Directed bench for lstm_gate_scheduler with a cycle-accurate engine model
// (idle one cycle, N calc cycles, then dataReady).
module tb_lstm_gate_scheduler;
    localparam int NROW = 16;
    localparam int BW   = 18;
    localparam int LW   = BW * NROW;
    localparam int N    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    gate_en = 4'd0;
    logic          busy, done, err, eng_rst, eng_done;
    logic [LW-1:0] eng_result;
    logic [1:0]    sel_gate;
    logic          sel_op;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [LW-1:0] res_data;
    logic [1:0]    res_gate;
    logic          res_op;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    logic hang = 1'b0;
    int ecnt = 0;

    lstm_gate_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .gate_en    (gate_en),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .eng_rst    (eng_rst),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .sel_gate   (sel_gate),
        .sel_op     (sel_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_gate   (res_gate),
        .res_op     (res_op)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] pat(input logic [1:0] g, input logic op);
        logic [LW-1:0] v;
        for (int r = 0; r < NROW; r++)
            v[r*BW +: BW] = BW'(r * 37 + int'(g) * 1000 + int'(op) * 500 + 7);
        return v;
    endfunction

    // Engine: cleared while eng_rst; output is only meaningful on eng_done.
    always_ff @(posedge clk) begin
        if (eng_rst) ecnt <= 0;
        else         ecnt <= ecnt + 1;
    end
    assign eng_done   = !hang && !eng_rst && (ecnt == N + 1);
    assign eng_result = eng_done ? pat(sel_gate, sel_op) : ~pat(sel_gate, sel_op);

    task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_seq(input logic [3:0] mask);
        gate_en = mask;
        start   = 1'b1;
        t0      = cyc;
        tick();
        start   = 1'b0;
    endtask

    // {busy,done,err,eng_rst,sel_gate,sel_op,res_valid,res_gate,res_op}
    function automatic logic [9:0] ctl();
        return {busy, done, err, eng_rst, sel_gate, sel_op, res_valid, res_gate, res_op};
    endfunction

    task automatic run_seq(input logic [3:0] mask, input int exp_first,
                           input int exp_done, input int poke);
        logic [1:0] eg[8];
        logic       eo[8];
        int n = 0, got = 0, first = -1, dcyc = -1, selbad = 0, rel;
        for (int g = 0; g < 4; g++) begin
            if (mask[g]) begin
                eg[n] = 2'(g); eo[n] = 1'b0;
                eg[n+1] = 2'(g); eo[n+1] = 1'b1;
                n += 2;
            end
        end
        res_ready = 1'b1;
        begin_seq(mask);
        rel = cyc - t0;
        while (dcyc < 0 && rel < 600) begin
            // Mid-sequence start and gate_en changes must be ignored.
            start   = (rel == poke);
            gate_en = (rel == poke) ? 4'hF : ~mask;
            if (res_valid && first < 0) first = rel;
            if (!eng_rst && (got >= n || sel_gate !== eg[got] || sel_op !== eo[got])) selbad++;
            if (res_valid && res_ready) begin
                if (got < n) begin
                    chk("res_gate", LW'(res_gate), LW'(eg[got]));
                    chk("res_op", LW'(res_op), LW'(eo[got]));
                    chk("res_data", res_data, pat(eg[got], eo[got]));
                end else begin
                    chk("extra_result", LW'(got), LW'(n));
                end
                got++;
            end
            if (done) dcyc = rel;
            if (dcyc < 0) begin
                tick();
                rel = cyc - t0;
            end
        end
        start = 1'b0;
        chk("first_valid_cycle", LW'(first), LW'(exp_first));
        chk("done_cycle", LW'(dcyc), LW'(exp_done));
        chk("job_count", LW'(got), LW'(n));
        chk("sel_stable_in_run", LW'(selbad), '0);
        tick();
        chk("done_one_cycle", LW'(done), '0);
        chk("idle_after_seq", LW'(busy), '0);
    endtask

    initial begin
        logic [LW-1:0] held;
        int bad, cnt, rel;

        // Reset state
        tick(); tick();
        chk("reset_ctl", LW'(ctl()), LW'(10'b0001_00_0_0_00_0));
        chk("reset_data", res_data, '0);
        reset = 1'b0;
        tick();

        // All gates, continuous ready
        run_seq(4'hF, 35, 280, -1);

        // Sparse mask, start poked while busy
        run_seq(4'b0101, 35, 140, 50);

        // Back-pressure on the first result
        res_ready = 1'b0;
        begin_seq(4'b0001);
        rel = 1;
        while (!res_valid && rel < 100) begin
            tick();
            rel = cyc - t0;
        end
        chk("bp_first_valid", LW'(rel), LW'(35));
        held = res_data;
        chk("bp_data", held, pat(2'd0, 1'b0));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_data !== held || res_gate !== 2'd0 || res_op !== 1'b0 ||
                eng_rst !== 1'b1 || res_valid !== 1'b1) bad++;
        end
        chk("bp_stable", LW'(bad), '0);
        res_ready = 1'b1;
        tick();
        chk("bp_run_after_hs", LW'({eng_rst, res_valid, sel_op}), LW'(3'b001));
        cnt = 0;
        while (!done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("bp_second_done", LW'(cnt), LW'(34));
        chk("bp_second_tag", LW'({res_gate, res_op}), LW'(3'b001));
        tick();

        // Empty mask
        begin_seq(4'b0000);
        chk("zero_done", LW'({done, res_valid, busy}), LW'(3'b100));
        tick();
        chk("zero_done_pulse", LW'({done, res_valid, busy}), LW'(3'b000));

        // Watchdog
        hang = 1'b1;
        begin_seq(4'b0010);
        while (cyc - t0 < 64) tick();
        chk("wd_before", LW'({busy, err}), LW'(2'b10));
        tick();
        chk("wd_err", LW'({busy, err, eng_rst}), LW'(3'b011));
        tick(); tick();
        chk("wd_sticky", LW'({busy, err, eng_rst}), LW'(3'b011));
        hang = 1'b0;
        run_seq(4'b1000, 35, 70, -1);
        chk("wd_cleared", LW'(err), '0);

        // Reset during the third job's RUN
        begin_seq(4'hF);
        while (cyc - t0 < 80) tick();
        chk("mid_run_busy", LW'({busy, eng_rst, sel_gate, sel_op}), LW'(5'b10010));
        reset = 1'b1;
        tick();
        chk("midreset_ctl", LW'(ctl()), LW'(10'b0001_00_0_0_00_0));
        chk("midreset_data", res_data, '0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (res_valid || busy) cnt++;
        end
        chk("midreset_quiet", LW'(cnt), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
